// File: rtl/ps2_packet_rx.sv
// PS/2 device-to-host receiver: pin sync and glitch filter, 11-bit frame decode,
// multi-byte packet assembly with error tagging, and a show-ahead packet FIFO.
`timescale 1ns/1ps
module ps2_packet_rx #(
  parameter int PKT_BYTES   = 3,
  parameter int FIFO_DEPTH  = 4,
  parameter int FILT_LEN    = 4,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                   clk_sys,
  input  logic                   rst_n,
  input  logic                   PS2_CLK,
  input  logic                   PS2_DATA,
  input  logic                   rd_en,
  output logic                   rd_vld,
  output logic [8*PKT_BYTES-1:0] rd_data,
  output logic                   rd_err,
  input  logic                   err_clr,
  output logic                   parity_err,
  output logic                   frame_err,
  output logic                   overflow
);

  localparam int PW    = 8 * PKT_BYTES;
  localparam int IDX_W = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int TO_W  = $clog2(TIMEOUT_CYC);
  localparam int FW    = $clog2(FILT_LEN) + 1;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(PKT_BYTES - 1);
  localparam logic [TO_W-1:0]  TO_MAX    = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [FW-1:0]    FILT_LAST = FW'(FILT_LEN - 1);
  localparam logic [AW:0]      FULL_CNT  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic              clk_p0, clk_p1, data_p0, data_p1;
  logic              filt_clk;
  logic [FW-1:0]     filt_cnt;
  logic              fall, d;
  state_t            state;
  logic [2:0]        bit_cnt;
  logic [7:0]        sh;
  logic              perr;
  logic [IDX_W-1:0]  byte_idx;
  logic              pkt_err;
  logic [PW-1:0]     pkt_buf, pkt_next;
  logic [TO_W-1:0]   to_cnt;
  logic              timeout, byte_bad, pkt_bad, push, pop, full, wr_ok;
  logic              perr_set, ferr_set, ovf_set;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic [PW:0]       mem [FIFO_DEPTH];
  logic [PW:0]       head;

  // Stage p0/p1: two-flop synchronisers, preset high to match an idle bus
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      clk_p0  <= 1'b1;
      clk_p1  <= 1'b1;
      data_p0 <= 1'b1;
      data_p1 <= 1'b1;
    end else begin
      clk_p0  <= PS2_CLK;
      clk_p1  <= clk_p0;
      data_p0 <= PS2_DATA;
      data_p1 <= data_p0;
    end
  end

  // Filtered clock follows the synced pin only after FILT_LEN consecutive differing samples
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_p1 == filt_clk) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FILT_LAST) begin
      filt_clk <= clk_p1;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + FW'(1);
    end
  end

  assign fall     = filt_clk && !clk_p1 && (filt_cnt == FILT_LAST);
  assign d        = data_p1;
  assign timeout  = !fall && (to_cnt == TO_MAX) && ((state != IDLE) || (byte_idx != '0));
  assign byte_bad = perr | ~d;
  assign pkt_bad  = pkt_err | byte_bad;
  assign push     = fall && (state == STOP) && (byte_idx == LAST_IDX);
  assign perr_set = fall && (state == PARITY) && ~^{sh, d};
  assign ferr_set = (fall && (state == STOP) && !d) || timeout;

  always_comb begin
    pkt_next = pkt_buf;
    pkt_next[{byte_idx, 3'b000} +: 8] = sh;
  end

  // Frame decode and packet assembly, advancing only on filtered falling edges
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      perr     <= 1'b0;
      byte_idx <= '0;
      pkt_err  <= 1'b0;
      to_cnt   <= '0;
    end else begin
      if (fall)
        to_cnt <= '0;
      else if (to_cnt != TO_MAX)
        to_cnt <= to_cnt + TO_W'(1);

      if (fall) begin
        case (state)
          IDLE: if (!d) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
          DATA: begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            perr  <= ~^{sh, d};
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (byte_idx == LAST_IDX) begin
              byte_idx <= '0;
              pkt_err  <= 1'b0;
            end else begin
              byte_idx <= byte_idx + IDX_W'(1);
              pkt_err  <= pkt_bad;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (timeout) begin
        state    <= IDLE;
        byte_idx <= '0;
        pkt_err  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (fall && (state == DATA)) sh <= {d, sh[7:1]};
    if (fall && (state == STOP)) pkt_buf <= pkt_next;
  end

  // Packet FIFO: a pop frees a slot in the same cycle, so push-while-full-and-pop is accepted
  assign rd_vld  = (count != '0);
  assign full    = (count == FULL_CNT);
  assign pop     = rd_vld && rd_en;
  assign wr_ok   = push && (!full || pop);
  assign ovf_set = push && full && !pop;
  assign head    = mem[rd_ptr];
  assign rd_data = rd_vld ? head[PW-1:0] : '0;
  assign rd_err  = rd_vld ? head[PW] : 1'b0;

  always_ff @(posedge clk_sys) begin
    if (wr_ok) mem[wr_ptr] <= {pkt_bad, pkt_next};
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      if (wr_ok && !pop)
        count <= count + (AW+1)'(1);
      else if (pop && !wr_ok)
        count <= count - (AW+1)'(1);
    end
  end

  // Sticky flags: a set event outranks a simultaneous clear
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (perr_set)     parity_err <= 1'b1;
      else if (err_clr) parity_err <= 1'b0;
      if (ferr_set)     frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
      if (ovf_set)      overflow <= 1'b1;
      else if (err_clr) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_packet_rx.sv
// Directed bench for ps2_packet_rx: table of 3-byte packets plus hand-written
// sequences for timeout, overflow, clock glitch and mid-frame reset.
`timescale 1ns/1ps
module tb_ps2_packet_rx;

  localparam int HALF = 10;

  logic        clk_sys = 1'b0;
  logic        rst_n = 1'b0;
  logic        PS2_CLK = 1'b1;
  logic        PS2_DATA = 1'b1;
  logic        rd_en = 1'b0;
  logic        err_clr = 1'b0;
  logic        rd_vld, rd_err, parity_err, frame_err, overflow;
  logic [23:0] rd_data;

  int checks = 0;
  int errors = 0;

  ps2_packet_rx #(
    .PKT_BYTES(3), .FIFO_DEPTH(4), .FILT_LEN(4), .TIMEOUT_CYC(400)
  ) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .PS2_CLK(PS2_CLK), .PS2_DATA(PS2_DATA),
    .rd_en(rd_en), .rd_vld(rd_vld), .rd_data(rd_data), .rd_err(rd_err),
    .err_clr(err_clr), .parity_err(parity_err), .frame_err(frame_err),
    .overflow(overflow)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]  b0, b1, b2;
    logic [2:0]  bad_par;
    logic [2:0]  bad_stop;
    logic [23:0] exp_data;
    logic        exp_err, exp_perr, exp_ferr;
  } vec_t;

  vec_t vecs[5];

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic v, input logic glitch);
    PS2_DATA = v;
    tick(3);
    if (glitch) begin
      PS2_CLK = 1'b0;
      tick(2);
      PS2_CLK = 1'b1;
    end
    tick(HALF - 3);
    PS2_CLK = 1'b0;
    tick(HALF);
    PS2_CLK = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_par, input logic bad_stop,
                           input int glitch_bit);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i], glitch_bit == i);
    send_bit((~^b) ^ bad_par, 1'b0);
    send_bit(~bad_stop, 1'b0);
    PS2_DATA = 1'b1;
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0, 1'b0, 1'b0, -1);
    send_byte(b1, 1'b0, 1'b0, -1);
    send_byte(b2, 1'b0, 1'b0, -1);
    tick(2);
  endtask

  task automatic pop1();
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
  endtask

  task automatic clear_flags();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'h08, 8'h10, 8'hF0, 3'b000, 3'b000, 24'hF01008, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'hAA, 8'h55, 8'h01, 3'b100, 3'b000, 24'h0155AA, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 8'h00, 8'h80, 3'b000, 3'b001, 24'h8000FF, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{8'h12, 8'h34, 8'h56, 3'b000, 3'b000, 24'h563412, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{8'h00, 8'hFF, 8'h7E, 3'b001, 3'b010, 24'h7EFF00, 1'b1, 1'b1, 1'b1};

    tick(3);
    chk("reset_rd_vld", rd_vld, 0);
    chk("reset_rd_data", rd_data, 0);
    chk("reset_rd_err", rd_err, 0);
    chk("reset_parity_err", parity_err, 0);
    chk("reset_frame_err", frame_err, 0);
    chk("reset_overflow", overflow, 0);
    rst_n = 1'b1;
    tick(3);

    pop1();
    chk("pop_empty_rd_vld", rd_vld, 0);

    for (int v = 0; v < 5; v++) begin
      send_byte(vecs[v].b0, vecs[v].bad_par[0], vecs[v].bad_stop[0], -1);
      send_byte(vecs[v].b1, vecs[v].bad_par[1], vecs[v].bad_stop[1], -1);
      send_byte(vecs[v].b2, vecs[v].bad_par[2], vecs[v].bad_stop[2], -1);
      tick(2);
      chk($sformatf("vec%0d_rd_vld", v), rd_vld, 1);
      chk($sformatf("vec%0d_rd_data", v), rd_data, vecs[v].exp_data);
      chk($sformatf("vec%0d_rd_err", v), rd_err, vecs[v].exp_err);
      chk($sformatf("vec%0d_parity_err", v), parity_err, vecs[v].exp_perr);
      chk($sformatf("vec%0d_frame_err", v), frame_err, vecs[v].exp_ferr);
      pop1();
      chk($sformatf("vec%0d_empty_after_pop", v), rd_vld, 0);
      clear_flags();
      chk($sformatf("vec%0d_perr_cleared", v), parity_err, 0);
      chk($sformatf("vec%0d_ferr_cleared", v), frame_err, 0);
    end

    // Two bytes then silence beyond the timeout: partial packet discarded
    send_byte(8'hAA, 1'b0, 1'b0, -1);
    send_byte(8'hBB, 1'b0, 1'b0, -1);
    tick(600);
    chk("timeout_no_push", rd_vld, 0);
    chk("timeout_frame_err", frame_err, 1);
    clear_flags();
    send_pkt(8'h01, 8'h02, 8'h03);
    chk("resync_rd_vld", rd_vld, 1);
    chk("resync_rd_data", rd_data, 24'h030201);
    chk("resync_rd_err", rd_err, 0);
    chk("resync_frame_err", frame_err, 0);
    pop1();

    // Five packets into a four-deep FIFO with no reads
    for (int k = 1; k <= 5; k++) begin
      send_pkt(8'(k), 8'(8'h10 + k), 8'(8'h20 + k));
      if (k == 4) chk("overflow_before_fifth", overflow, 0);
    end
    chk("overflow_set", overflow, 1);
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("ovf_pop%0d_rd_vld", k), rd_vld, 1);
      chk($sformatf("ovf_pop%0d_rd_data", k), rd_data,
          {8'(8'h20 + k), 8'(8'h10 + k), 8'(k)});
      pop1();
    end
    chk("ovf_drained", rd_vld, 0);
    clear_flags();
    chk("overflow_cleared", overflow, 0);

    // Short low glitch on PS2_CLK in the middle of a byte
    send_byte(8'h5A, 1'b0, 1'b0, -1);
    send_byte(8'hC3, 1'b0, 1'b0, 3);
    send_byte(8'h3C, 1'b0, 1'b0, -1);
    tick(2);
    chk("glitch_rd_vld", rd_vld, 1);
    chk("glitch_rd_data", rd_data, 24'h3CC35A);
    chk("glitch_rd_err", rd_err, 0);
    chk("glitch_parity_err", parity_err, 0);
    chk("glitch_frame_err", frame_err, 0);

    // Reset while a packet is queued and a byte is in flight
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    rst_n = 1'b0;
    PS2_DATA = 1'b1;
    tick(2);
    chk("midreset_rd_vld", rd_vld, 0);
    chk("midreset_rd_data", rd_data, 0);
    rst_n = 1'b1;
    tick(3);
    send_pkt(8'h11, 8'h22, 8'h33);
    chk("postreset_rd_vld", rd_vld, 1);
    chk("postreset_rd_data", rd_data, 24'h332211);
    chk("postreset_rd_err", rd_err, 0);
    chk("postreset_frame_err", frame_err, 0);
    pop1();
    chk("postreset_empty", rd_vld, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
